operand_loader: RTL and testbench

//   Upstream stage that feeds the bitwise OR/AND selector. Captures operand A,

---
 rtl/operand_loader_if.sv | 29 ++
 rtl/operand_loader.sv | 115 +++++++++++
 tb/tb_operand_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/operand_loader_if.sv
// Bus between the operand loader and its neighbours: the byte-bus/strobe
// inputs, the downstream handshake and the status outputs.
interface operand_loader_if #(
   parameter int WIDTH = 8
);
   logic             ena;
   logic [WIDTH-1:0] data_in;
   logic             load;
   logic             op_in;
   logic             abort;
   logic             op_ready;
   logic [WIDTH-1:0] opnd_a;
   logic [WIDTH-1:0] opnd_b;
   logic             op_sel;
   logic             op_valid;
   logic             busy;
   logic             timeout_err;
   logic [7:0]       issue_cnt;

   modport master (
      output ena, data_in, load, op_in, abort, op_ready,
      input  opnd_a, opnd_b, op_sel, op_valid, busy, timeout_err, issue_cnt
   );

   modport slave (
      input  ena, data_in, load, op_in, abort, op_ready,
      output opnd_a, opnd_b, op_sel, op_valid, busy, timeout_err, issue_cnt
   );
endinterface

// File: rtl/operand_loader.sv
// Captures operand A, then operand B plus op select, on load-strobe rising edges
// and presents them downstream with valid/ready, a timeout and a transfer counter.
module operand_loader #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 255
) (
   input logic             clk,
   input logic             rst_n,
   operand_loader_if.slave bus
);
   localparam logic [1:0] S_A     = 2'd0;
   localparam logic [1:0] S_B     = 2'd1;
   localparam logic [1:0] S_ISSUE = 2'd2;

   // A zero TIMEOUT disables the timeout; keep the timer one bit wide in that case.
   localparam bit                TIMEOUT_EN = (TIMEOUT > 0);
   localparam int                TW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0]     TIMER_LAST = TW'(TIMEOUT - 1);

   logic [1:0]       state_reg, state_next;
   logic [WIDTH-1:0] opnd_a_reg, opnd_a_next;
   logic [WIDTH-1:0] opnd_b_reg, opnd_b_next;
   logic             op_sel_reg, op_sel_next;
   logic             op_valid_reg, op_valid_next;
   logic             timeout_err_reg, timeout_err_next;
   logic [7:0]       issue_cnt_reg, issue_cnt_next;
   logic [TW-1:0]    timer_reg, timer_next;
   logic             load_q_reg;
   logic             load_edge;

   assign load_edge = bus.load & ~load_q_reg & bus.ena;

   always_comb begin
      state_next       = state_reg;
      opnd_a_next      = opnd_a_reg;
      opnd_b_next      = opnd_b_reg;
      op_sel_next      = op_sel_reg;
      op_valid_next    = op_valid_reg;
      timeout_err_next = timeout_err_reg;
      issue_cnt_next   = issue_cnt_reg;
      timer_next       = timer_reg;

      if (bus.abort) begin
         state_next       = S_A;
         op_valid_next    = 1'b0;
         timer_next       = '0;
         timeout_err_next = 1'b0;
      end else if (bus.ena) begin
         case (state_reg)
            S_A: begin
               if (load_edge) begin
                  opnd_a_next = bus.data_in;
                  state_next  = S_B;
               end
            end
            S_B: begin
               if (load_edge) begin
                  opnd_b_next   = bus.data_in;
                  op_sel_next   = bus.op_in;
                  op_valid_next = 1'b1;
                  timer_next    = '0;
                  state_next    = S_ISSUE;
               end
            end
            S_ISSUE: begin
               // Acceptance beats the timeout when both land on the same edge.
               if (op_valid_reg && bus.op_ready) begin
                  op_valid_next  = 1'b0;
                  issue_cnt_next = issue_cnt_reg + 8'd1;
                  state_next     = S_A;
               end else if (TIMEOUT_EN && (timer_reg == TIMER_LAST)) begin
                  op_valid_next    = 1'b0;
                  timeout_err_next = 1'b1;
                  state_next       = S_A;
               end else begin
                  timer_next = timer_reg + 1'b1;
               end
            end
            default: state_next = S_A;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg       <= S_A;
         opnd_a_reg      <= '0;
         opnd_b_reg      <= '0;
         op_sel_reg      <= 1'b0;
         op_valid_reg    <= 1'b0;
         timeout_err_reg <= 1'b0;
         issue_cnt_reg   <= 8'd0;
         timer_reg       <= '0;
         load_q_reg      <= 1'b0;
      end else begin
         state_reg       <= state_next;
         opnd_a_reg      <= opnd_a_next;
         opnd_b_reg      <= opnd_b_next;
         op_sel_reg      <= op_sel_next;
         op_valid_reg    <= op_valid_next;
         timeout_err_reg <= timeout_err_next;
         issue_cnt_reg   <= issue_cnt_next;
         timer_reg       <= timer_next;
         load_q_reg      <= bus.load;
      end
   end

   assign bus.opnd_a      = opnd_a_reg;
   assign bus.opnd_b      = opnd_b_reg;
   assign bus.op_sel      = op_sel_reg;
   assign bus.op_valid    = op_valid_reg;
   assign bus.busy        = (state_reg != S_A);
   assign bus.timeout_err = timeout_err_reg;
   assign bus.issue_cnt   = issue_cnt_reg;
endmodule

// File: tb/tb_operand_loader.sv
// Directed scenarios plus random traffic on operand_loader (TIMEOUT=4), each
// cycle compared against a transaction-level model of the loader.
module tb_operand_loader;
   localparam int WIDTH   = 8;
   localparam int TIMEOUT = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   operand_loader_if #(.WIDTH(WIDTH)) bus ();
   operand_loader #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Model: "have_a" means A captured, "valid" means a pair is on offer,
   // "waited" counts cycles the pair has been on offer without acceptance.
   logic [7:0] m_a, m_b, m_cnt, prev_cnt;
   bit         m_op, m_valid, m_have_a, m_err, m_load_q;
   int         m_waited;

   task automatic model_step();
      bit rise;
      if (!rst_n) begin
         m_a = 0; m_b = 0; m_op = 0; m_valid = 0; m_have_a = 0;
         m_err = 0; m_cnt = 0; m_waited = 0; m_load_q = 0;
      end else begin
         rise     = bus.load && !m_load_q && bus.ena;
         m_load_q = bus.load;
         if (bus.abort) begin
            m_have_a = 0; m_valid = 0; m_waited = 0; m_err = 0;
         end else if (bus.ena) begin
            if (m_valid) begin
               if (bus.op_ready) begin
                  m_valid = 0;
                  m_cnt   = m_cnt + 8'd1;
               end else if (m_waited + 1 == TIMEOUT) begin
                  m_valid = 0;
                  m_err   = 1;
               end else begin
                  m_waited++;
               end
            end else if (rise) begin
               if (!m_have_a) begin
                  m_a      = bus.data_in;
                  m_have_a = 1;
               end else begin
                  m_b      = bus.data_in;
                  m_op     = bus.op_in;
                  m_valid  = 1;
                  m_have_a = 0;
                  m_waited = 0;
               end
            end
         end
      end
   endtask

   task automatic compare_all();
      check_eq("opnd_a", bus.opnd_a, m_a);
      check_eq("opnd_b", bus.opnd_b, m_b);
      check_eq("op_sel", bus.op_sel, m_op);
      check_eq("op_valid", bus.op_valid, m_valid);
      check_eq("busy", bus.busy, m_have_a || m_valid);
      check_eq("timeout_err", bus.timeout_err, m_err);
      check_eq("issue_cnt", bus.issue_cnt, m_cnt);
      if (m_cnt != prev_cnt)
         $display("xfer cnt=%0d a=%02h b=%02h op=%0d", m_cnt, m_a, m_b, m_op);
      prev_cnt = m_cnt;
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic pulse(input logic [7:0] d, input logic op);
      bus.data_in = d;
      bus.op_in   = op;
      bus.load    = 1'b1;
      step();
      bus.load = 1'b0;
      step();
   endtask

   int vc;

   initial begin
      prev_cnt     = 0;
      bus.ena      = 1'b1;
      bus.data_in  = '0;
      bus.load     = 1'b0;
      bus.op_in    = 1'b0;
      bus.abort    = 1'b0;
      bus.op_ready = 1'b0;
      rst_n        = 1'b0;
      step();
      step();
      check_eq("rst_valid", bus.op_valid, 1'b0);
      check_eq("rst_cnt", bus.issue_cnt, 8'd0);
      rst_n = 1'b1;

      // Basic load and transfer.
      bus.op_ready = 1'b1;
      pulse(8'hA5, 1'b0);
      bus.data_in = 8'h3C; bus.op_in = 1'b0; bus.load = 1'b1;
      step();
      check_eq("t1_valid", bus.op_valid, 1'b1);
      check_eq("t1_a", bus.opnd_a, 8'hA5);
      check_eq("t1_b", bus.opnd_b, 8'h3C);
      bus.load = 1'b0;
      step();
      check_eq("t1_cnt", bus.issue_cnt, 8'd1);
      check_eq("t1_busy", bus.busy, 1'b0);

      // Held load captures only A.
      bus.op_ready = 1'b0;
      bus.data_in  = 8'h11;
      bus.load     = 1'b1;
      repeat (10) step();
      check_eq("t2_a", bus.opnd_a, 8'h11);
      check_eq("t2_busy", bus.busy, 1'b1);
      bus.load = 1'b0;
      step();

      // Timeout: valid exactly TIMEOUT cycles.
      bus.data_in = 8'h22; bus.load = 1'b1;
      step();
      vc = bus.op_valid ? 1 : 0;
      bus.load = 1'b0;
      repeat (7) begin
         step();
         if (bus.op_valid) vc++;
      end
      check_eq("t3_valid_cycles", vc, TIMEOUT);
      check_eq("t3_err", bus.timeout_err, 1'b1);
      check_eq("t3_busy", bus.busy, 1'b0);

      bus.abort = 1'b1; step(); bus.abort = 1'b0;
      check_eq("abort_clr_err", bus.timeout_err, 1'b0);

      // Ready arrives in the last valid cycle: transfer wins.
      pulse(8'h5A, 1'b1);
      pulse(8'hC3, 1'b1);
      step();
      step();
      bus.op_ready = 1'b1;
      step();
      bus.op_ready = 1'b0;
      check_eq("t4_err", bus.timeout_err, 1'b0);
      check_eq("t4_cnt", bus.issue_cnt, 8'd2);

      // Abort during issue; load edge in issue is dropped.
      pulse(8'h01, 1'b0);
      pulse(8'h02, 1'b0);
      pulse(8'h03, 1'b0);
      bus.abort = 1'b1; step(); bus.abort = 1'b0;
      check_eq("t5_valid", bus.op_valid, 1'b0);
      check_eq("t5_cnt", bus.issue_cnt, 8'd2);
      pulse(8'h77, 1'b0);
      check_eq("t5_a", bus.opnd_a, 8'h77);
      check_eq("t5_busy", bus.busy, 1'b1);
      bus.abort = 1'b1; step(); bus.abort = 1'b0;

      // ena low in issue holds valid and blocks the transfer.
      pulse(8'h10, 1'b0);
      bus.data_in = 8'h20; bus.load = 1'b1;
      step();
      bus.load = 1'b0;
      bus.ena = 1'b0; bus.op_ready = 1'b1;
      repeat (3) step();
      check_eq("ena_valid", bus.op_valid, 1'b1);
      check_eq("ena_cnt", bus.issue_cnt, 8'd2);
      bus.ena = 1'b1;
      step();
      check_eq("ena_xfer", bus.issue_cnt, 8'd3);
      bus.op_ready = 1'b0;

      // Reset while issuing.
      pulse(8'h44, 1'b0);
      pulse(8'h55, 1'b1);
      rst_n = 1'b0; step(); rst_n = 1'b1;
      check_eq("rst_issue_valid", bus.op_valid, 1'b0);
      check_eq("rst_issue_cnt", bus.issue_cnt, 8'd0);

      // 256 transfers wrap the counter.
      bus.op_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         pulse(8'(i), 1'b0);
         pulse(8'(~i), 1'b1);
         if (i == 254) check_eq("wrap_255", bus.issue_cnt, 8'd255);
      end
      check_eq("wrap_0", bus.issue_cnt, 8'd0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         rst_n        = ($urandom_range(0, 99) != 0);
         bus.abort    = ($urandom_range(0, 49) == 0);
         bus.ena      = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 2) == 0) bus.load = ~bus.load;
         bus.data_in  = 8'($urandom);
         bus.op_in    = 1'($urandom);
         bus.op_ready = ($urandom_range(0, 3) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
